// File: rtl/cricket_pkg.sv
// Shared types, field widths and defaults for the cricket match datapath.
package cricket_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INN1   = 3'd1,
        ST_BREAK  = 3'd2,
        ST_INN2   = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    localparam logic [2:0] OUTCOME_WICKET = 3'd7;

    localparam int unsigned MAX_BALLS_DEF    = 120;
    localparam int unsigned MAX_WICKETS_DEF  = 10;
    localparam int unsigned BREAK_CYCLES_DEF = 16;

    localparam int unsigned RUN_W  = 8;
    localparam int unsigned WKT_W  = 4;
    localparam int unsigned BALL_W = 7;
    localparam int unsigned TEAM_W = RUN_W + WKT_W;

    // Score record layout seen by the comparator and display: {runs, wickets}.
    function automatic logic [TEAM_W-1:0] team_data(input logic [RUN_W-1:0] runs,
                                                    input logic [WKT_W-1:0] wkts);
        return {runs, wkts};
    endfunction

endpackage

// File: rtl/innings_accumulator.sv
// Per-team run/wicket/ball counters with saturation; next values exposed for the end test.
module innings_accumulator
    import cricket_pkg::*;
(
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic              clear,
    input  logic              ball_en,
    input  logic [2:0]        outcome,
    output logic [RUN_W-1:0]  runs,
    output logic [WKT_W-1:0]  wickets,
    output logic [BALL_W-1:0] balls,
    output logic [RUN_W-1:0]  runs_nxt,
    output logic [WKT_W-1:0]  wickets_nxt,
    output logic [BALL_W-1:0] balls_nxt
);

    logic [RUN_W-1:0]  runs_q, runs_d;
    logic [WKT_W-1:0]  wickets_q, wickets_d;
    logic [BALL_W-1:0] balls_q, balls_d;
    logic [RUN_W:0]    run_sum;

    // Next-value computation: clear wins over a ball, every counter saturates.
    always_comb begin
        runs_d    = runs_q;
        wickets_d = wickets_q;
        balls_d   = balls_q;
        run_sum   = {1'b0, runs_q} + (RUN_W+1)'(outcome);
        if (clear) begin
            runs_d    = '0;
            wickets_d = '0;
            balls_d   = '0;
        end else if (ball_en) begin
            balls_d = (balls_q == '1) ? balls_q : balls_q + BALL_W'(1);
            if (outcome == OUTCOME_WICKET) begin
                wickets_d = (wickets_q == '1) ? wickets_q : wickets_q + WKT_W'(1);
            end else begin
                runs_d = run_sum[RUN_W] ? '1 : run_sum[RUN_W-1:0];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            runs_q    <= '0;
            wickets_q <= '0;
            balls_q   <= '0;
        end else begin
            runs_q    <= runs_d;
            wickets_q <= wickets_d;
            balls_q   <= balls_d;
        end
    end

    assign runs        = runs_q;
    assign wickets     = wickets_q;
    assign balls       = balls_q;
    assign runs_nxt    = runs_d;
    assign wickets_nxt = wickets_d;
    assign balls_nxt   = balls_d;

endmodule

// File: rtl/match_controller.sv
// Two-innings match sequencer: ball handshake, innings/match end, break timer, result flags.
module match_controller
    import cricket_pkg::*;
#(
    parameter int unsigned MAX_BALLS    = MAX_BALLS_DEF,
    parameter int unsigned MAX_WICKETS  = MAX_WICKETS_DEF,
    parameter int unsigned BREAK_CYCLES = BREAK_CYCLES_DEF
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic              start,
    input  logic              ball_valid,
    input  logic [2:0]        ball_outcome,
    output logic              ball_ready,
    output logic [2:0]        state,
    output logic              batting_team,
    output logic [TEAM_W-1:0] team1_data,
    output logic [TEAM_W-1:0] team2_data,
    output logic [BALL_W-1:0] team1_balls,
    output logic [BALL_W-1:0] team2_balls,
    output logic              inning_over,
    output logic              game_over,
    output logic              winner,
    output logic              tie
);

    localparam int unsigned BRK_W = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [BRK_W-1:0] brk_q, brk_d;
    logic             batting_q, batting_d;
    logic             inning_over_q, inning_over_d;
    logic             game_over_q, game_over_d;
    logic             winner_q, winner_d;
    logic             tie_q, tie_d;

    logic              clear_scores, accept, en1, en2, inn1_end, inn2_end;
    logic [RUN_W-1:0]  r1, r2, r1_nxt, r2_nxt;
    logic [WKT_W-1:0]  w1, w2, w1_nxt, w2_nxt;
    logic [BALL_W-1:0] b1, b2, b1_nxt, b2_nxt;

    assign clear_scores = start && ((state_q == ST_IDLE) || (state_q == ST_RESULT));
    assign ball_ready   = (state_q == ST_INN1) || (state_q == ST_INN2);
    assign accept       = ball_valid && ball_ready;
    assign en1          = accept && (state_q == ST_INN1);
    assign en2          = accept && (state_q == ST_INN2);

    // r1_nxt equals r1 throughout INN2 since team1 takes no balls there.
    assign inn1_end = en1 && ((w1_nxt == WKT_W'(MAX_WICKETS)) || (b1_nxt == BALL_W'(MAX_BALLS)));
    assign inn2_end = en2 && ((r2_nxt > r1_nxt) || (w2_nxt == WKT_W'(MAX_WICKETS)) ||
                              (b2_nxt == BALL_W'(MAX_BALLS)));

    innings_accumulator u_team1 (
        .clk_fpga    (clk_fpga),
        .reset       (reset),
        .clear       (clear_scores),
        .ball_en     (en1),
        .outcome     (ball_outcome),
        .runs        (r1),
        .wickets     (w1),
        .balls       (b1),
        .runs_nxt    (r1_nxt),
        .wickets_nxt (w1_nxt),
        .balls_nxt   (b1_nxt)
    );

    innings_accumulator u_team2 (
        .clk_fpga    (clk_fpga),
        .reset       (reset),
        .clear       (clear_scores),
        .ball_en     (en2),
        .outcome     (ball_outcome),
        .runs        (r2),
        .wickets     (w2),
        .balls       (b2),
        .runs_nxt    (r2_nxt),
        .wickets_nxt (w2_nxt),
        .balls_nxt   (b2_nxt)
    );

    // Next-state, break timer and result flag logic.
    always_comb begin
        state_d       = state_q;
        brk_d         = brk_q;
        batting_d     = batting_q;
        inning_over_d = 1'b0;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        tie_d         = tie_q;
        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (start) begin
                    state_d     = ST_INN1;
                    batting_d   = 1'b0;
                    game_over_d = 1'b0;
                    winner_d    = 1'b0;
                    tie_d       = 1'b0;
                end
            end
            ST_INN1: begin
                if (inn1_end) begin
                    state_d       = ST_BREAK;
                    brk_d         = BRK_W'(BREAK_CYCLES - 1);
                    inning_over_d = 1'b1;
                end
            end
            ST_BREAK: begin
                if (brk_q == '0) begin
                    state_d   = ST_INN2;
                    batting_d = 1'b1;
                end else begin
                    brk_d = brk_q - BRK_W'(1);
                end
            end
            ST_INN2: begin
                if (inn2_end) begin
                    state_d       = ST_RESULT;
                    inning_over_d = 1'b1;
                    game_over_d   = 1'b1;
                    winner_d      = (r2_nxt > r1_nxt);
                    tie_d         = (r2_nxt == r1_nxt);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            brk_q         <= '0;
            batting_q     <= 1'b0;
            inning_over_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            tie_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            brk_q         <= brk_d;
            batting_q     <= batting_d;
            inning_over_q <= inning_over_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            tie_q         <= tie_d;
        end
    end

    assign state        = state_q;
    assign batting_team = batting_q;
    assign team1_data   = team_data(r1, w1);
    assign team2_data   = team_data(r2, w2);
    assign team1_balls  = b1;
    assign team2_balls  = b2;
    assign inning_over  = inning_over_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench: innings-end expectations are queued by stimulus, checked on inning_over.
module tb_match_controller;

    logic        clk_fpga = 1'b0;
    logic        reset, start, ball_valid;
    logic [2:0]  ball_outcome;
    logic        ball_ready, batting_team, inning_over, game_over, winner, tie;
    logic [2:0]  state;
    logic [11:0] team1_data, team2_data;
    logic [6:0]  team1_balls, team2_balls;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int st; int d1; int d2; int b1; int b2; int go; int win; int tie;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk_fpga = ~clk_fpga;

    match_controller #(.MAX_BALLS(120), .MAX_WICKETS(10), .BREAK_CYCLES(16)) dut (
        .clk_fpga     (clk_fpga),
        .reset        (reset),
        .start        (start),
        .ball_valid   (ball_valid),
        .ball_outcome (ball_outcome),
        .ball_ready   (ball_ready),
        .state        (state),
        .batting_team (batting_team),
        .team1_data   (team1_data),
        .team2_data   (team2_data),
        .team1_balls  (team1_balls),
        .team2_balls  (team2_balls),
        .inning_over  (inning_over),
        .game_over    (game_over),
        .winner       (winner),
        .tie          (tie)
    );

    function automatic int pk(input int runs, input int wkts);
        return (runs << 4) | wkts;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int st, input int d1, input int d2, input int b1, input int b2,
                        input int go, input int win, input int t);
        exp_t e;
        e.st = st; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
        e.go = go; e.win = win; e.tie = t;
        sb_q.push_back(e);
    endtask

    // Monitor: every inning_over pulse must match the oldest queued expectation.
    always @(negedge clk_fpga) begin
        if (!reset && inning_over === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: inning_over with empty queue, state %0d", state);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_state", int'(state), e.st);
                check("sb_team1_data", int'(team1_data), e.d1);
                check("sb_team2_data", int'(team2_data), e.d2);
                check("sb_team1_balls", int'(team1_balls), e.b1);
                check("sb_team2_balls", int'(team2_balls), e.b2);
                check("sb_game_over", int'(game_over), e.go);
                check("sb_winner", int'(winner), e.win);
                check("sb_tie", int'(tie), e.tie);
            end
        end
    end

    task automatic play(input int n, input logic [2:0] o);
        for (int i = 0; i < n; i++) begin
            ball_valid   = 1'b1;
            ball_outcome = o;
            @(negedge clk_fpga);
        end
        ball_valid = 1'b0;
    endtask

    task automatic wait_state(input int s, input string name);
        int n;
        n = 0;
        while (int'(state) != s && n < 200) begin
            @(negedge clk_fpga);
            n++;
        end
        check(name, int'(state), s);
    endtask

    task automatic start_match(input string tag);
        start = 1'b1;
        @(negedge clk_fpga);
        start = 1'b0;
        check({tag, "_state"}, int'(state), 1);
        check({tag, "_team1_data"}, int'(team1_data), 0);
        check({tag, "_team2_data"}, int'(team2_data), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_ready"}, int'(ball_ready), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_ready"}, int'(ball_ready), 0);
        check({tag, "_batting"}, int'(batting_team), 0);
        check({tag, "_team1_data"}, int'(team1_data), 0);
        check({tag, "_team2_data"}, int'(team2_data), 0);
        check({tag, "_team1_balls"}, int'(team1_balls), 0);
        check({tag, "_team2_balls"}, int'(team2_balls), 0);
        check({tag, "_inning_over"}, int'(inning_over), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_winner"}, int'(winner), 0);
        check({tag, "_tie"}, int'(tie), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int brk_cycles;
        int ready_seen;
        reset = 1'b1; start = 1'b0; ball_valid = 1'b0; ball_outcome = 3'd0;
        repeat (2) @(negedge clk_fpga);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk_fpga);
        check("idle_hold", int'(state), 0);

        // Full 120-ball innings of singles, then the break timer.
        start_match("t1");
        push(2, pk(120, 0), 0, 120, 0, 0, 0, 0);
        play(119, 3'd1);
        check("t1_no_early_end", int'(state), 1);
        check("t1_balls_119", int'(team1_balls), 119);
        play(1, 3'd1);
        brk_cycles = 0;
        ready_seen = 0;
        while (int'(state) == 2 && brk_cycles < 100) begin
            brk_cycles++;
            if (ball_ready) ready_seen++;
            @(negedge clk_fpga);
        end
        check("t1_break_len", brk_cycles, 16);
        check("t1_break_ready", ready_seen, 0);
        check("t1_inn2_state", int'(state), 3);
        check("t1_batting", int'(batting_team), 1);
        // Team2 all out for 0: team1 wins.
        push(4, pk(120, 0), pk(0, 10), 120, 10, 1, 0, 0);
        play(10, 3'd7);
        check("t1_result_hold", int'(state), 4);
        repeat (3) @(negedge clk_fpga);
        check("t1_held_game_over", int'(game_over), 1);
        check("t1_held_team2", int'(team2_data), pk(0, 10));

        // Ten wickets end INN1; a ball in BREAK is dropped.
        start_match("t2");
        push(2, pk(0, 10), 0, 10, 0, 0, 0, 0);
        play(10, 3'd7);
        ball_valid = 1'b1; ball_outcome = 3'd7;
        @(negedge clk_fpga);
        ball_valid = 1'b0;
        check("t2_drop_team1_data", int'(team1_data), pk(0, 10));
        check("t2_drop_team1_balls", int'(team1_balls), 10);
        wait_state(3, "t2_reach_inn2");
        // 0-0 after both sides are all out: tie.
        push(4, pk(0, 10), pk(0, 10), 10, 10, 1, 0, 1);
        play(10, 3'd7);

        // Team1 30; chase completes with 31 on the sixth ball.
        start_match("t3");
        push(2, pk(30, 10), 0, 15, 0, 0, 0, 0);
        play(5, 3'd6);
        play(10, 3'd7);
        wait_state(3, "t3_reach_inn2");
        push(4, pk(30, 10), pk(31, 0), 15, 6, 1, 1, 0);
        play(5, 3'd6);
        check("t3_chase_pending", int'(team2_data), pk(30, 0));
        play(1, 3'd1);

        // Team1 20; team2 levels on 20 then loses all wickets: tie.
        start_match("t4");
        push(2, pk(20, 10), 0, 30, 0, 0, 0, 0);
        play(20, 3'd1);
        play(10, 3'd7);
        wait_state(3, "t4_reach_inn2");
        push(4, pk(20, 10), pk(20, 10), 30, 15, 1, 0, 1);
        play(3, 3'd6);
        play(2, 3'd1);
        check("t4_level_no_end", int'(state), 3);
        play(10, 3'd7);

        // Run saturation at 255.
        start_match("t5");
        play(42, 3'd6);
        check("t5_runs_252", int'(team1_data), pk(252, 0));
        play(8, 3'd6);
        check("t5_sat_team1_data", int'(team1_data), pk(255, 0));
        check("t5_sat_balls", int'(team1_balls), 50);
        push(2, pk(255, 10), 0, 60, 0, 0, 0, 0);
        play(10, 3'd7);
        wait_state(3, "t5_reach_inn2");
        play(3, 3'd4);
        check("t6_pre_reset_team2", int'(team2_data), pk(12, 0));

        // Reset mid-INN2 with a ball pending, then a clean restart.
        reset = 1'b1; ball_valid = 1'b1; ball_outcome = 3'd6;
        @(negedge clk_fpga);
        check_zero("t6_reset");
        reset = 1'b0; ball_valid = 1'b0;
        @(negedge clk_fpga);
        check("t6_idle_after", int'(state), 0);
        start_match("t6");
        play(1, 3'd3);
        check("t6_first_ball_data", int'(team1_data), pk(3, 0));
        check("t6_first_ball_balls", int'(team1_balls), 1);

        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
